// File: rtl/euler_acc_ctrl.sv
// Euler-step sequencer for one matrix-vector product, row by row.
// Ports: clk, rst_async, start, dim_m1, abort, mul_done in; mul_start,
//   row_idx, col_idx, acc_clr_n, row_valid, busy, done, err out.
module euler_acc_ctrl #(
   parameter int DIM_W  = 3,
   parameter int TO_CYC = 15,
   parameter int TO_W   = 4
) (
   input  logic             clk,
   input  logic             rst_async,
   input  logic             start,
   input  logic [DIM_W-1:0] dim_m1,
   input  logic             abort,
   input  logic             mul_done,
   output logic             mul_start,
   output logic [DIM_W-1:0] row_idx,
   output logic [DIM_W-1:0] col_idx,
   output logic             acc_clr_n,
   output logic             row_valid,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [2:0] {
      IDLE, CLEAR, ISSUE, WAIT, ROWEND, FINISH, ERR
   } state_t;

   // Last WAIT cycle index before a multiply is declared lost.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

   state_t           state, state_nx;
   logic [DIM_W-1:0] row, row_nx;
   logic [DIM_W-1:0] col, col_nx;
   logic [DIM_W-1:0] dim, dim_nx;
   logic [TO_W-1:0]  tcnt, tcnt_nx;

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state <= IDLE;
         row   <= '0;
         col   <= '0;
         dim   <= '0;
         tcnt  <= '0;
      end else begin
         state <= state_nx;
         row   <= row_nx;
         col   <= col_nx;
         dim   <= dim_nx;
         tcnt  <= tcnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      row_nx   = row;
      col_nx   = col;
      dim_nx   = dim;
      tcnt_nx  = tcnt;
      if (abort) begin
         state_nx = IDLE;
         row_nx   = '0;
         col_nx   = '0;
         dim_nx   = '0;
         tcnt_nx  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dim_nx   = dim_m1;
                  row_nx   = '0;
                  col_nx   = '0;
                  state_nx = CLEAR;
               end
            end
            CLEAR: state_nx = ISSUE;
            ISSUE: begin
               tcnt_nx  = '0;
               state_nx = WAIT;
            end
            WAIT: begin
               // mul_done beats a timeout landing in the same cycle
               if (mul_done) begin
                  if (col == dim) begin
                     state_nx = ROWEND;
                  end else begin
                     col_nx   = col + DIM_W'(1);
                     state_nx = ISSUE;
                  end
               end else if (tcnt == TO_LAST) begin
                  state_nx = ERR;
               end else begin
                  tcnt_nx = tcnt + TO_W'(1);
               end
            end
            ROWEND: begin
               if (row == dim) begin
                  state_nx = FINISH;
               end else begin
                  row_nx   = row + DIM_W'(1);
                  col_nx   = '0;
                  state_nx = CLEAR;
               end
            end
            FINISH: state_nx = IDLE;
            ERR:    state_nx = ERR;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Outputs depend on registered state only.
   always_comb begin
      mul_start = (state == ISSUE);
      row_valid = (state == ROWEND);
      done      = (state == FINISH);
      err       = (state == ERR);
      busy      = (state != IDLE) && (state != ERR);
      acc_clr_n = (state != IDLE) && (state != CLEAR) && (state != ERR);
      row_idx   = row;
      col_idx   = col;
   end

endmodule

// File: tb/tb_euler_acc_ctrl.sv
// Directed bench for euler_acc_ctrl with a small multiplier responder.
// Ports: drives every DUT input, observes every DUT output.
module tb_euler_acc_ctrl;

   logic       clk = 1'b0;
   logic       rst_async;
   logic       start;
   logic [2:0] dim_m1;
   logic       abort;
   logic       mul_done;
   logic       mul_start;
   logic [2:0] row_idx;
   logic [2:0] col_idx;
   logic       acc_clr_n;
   logic       row_valid;
   logic       busy;
   logic       done;
   logic       err;

   int vectors = 0;
   int miscompares = 0;
   int terms, rvs, clrs, errs, done_cyc, ms_cyc, rv_cyc;
   bit fin;

   euler_acc_ctrl #(.DIM_W(3), .TO_CYC(15), .TO_W(4)) dut (
      .clk(clk),
      .rst_async(rst_async),
      .start(start),
      .dim_m1(dim_m1),
      .abort(abort),
      .mul_done(mul_done),
      .mul_start(mul_start),
      .row_idx(row_idx),
      .col_idx(col_idx),
      .acc_clr_n(acc_clr_n),
      .row_valid(row_valid),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one step as the multiplier. Returns at the ISSUE cycle of
   // term (sr,sc) when stop_en is set, otherwise after done.
   task automatic run(input int dim, input bit rnd, input bit spur,
                      input bit stop_en, input int sr, input int sc);
      int er, ec, wc;
      bit pend;
      terms = 0; rvs = 0; clrs = 0; errs = 0;
      done_cyc = 0; ms_cyc = 0; rv_cyc = 0;
      er = 0; ec = 0; wc = 0; pend = 0; fin = 0;
      abort = 1'b0;
      mul_done = 1'b0;
      dim_m1 = dim[2:0];
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n <= 2000 && !fin; n++) begin
         if (mul_start) begin
            chk("term_rc", 32'({row_idx, col_idx}), 32'({er[2:0], ec[2:0]}));
            if (ms_cyc == 0) ms_cyc = n;
            mul_done = 1'b0;
            if (stop_en && er == sr && ec == sc) begin
               fin = 1;
            end else begin
               terms++;
               pend = 1;
               wc = rnd ? int'($urandom_range(0, 14)) : 0;
               ec++;
               if (ec > dim) begin
                  ec = 0;
                  er++;
               end
            end
         end else if (pend) begin
            if (wc == 0) begin
               mul_done = 1'b1;
               pend = 0;
            end else begin
               wc--;
               mul_done = 1'b0;
            end
         end else begin
            mul_done = spur && ((busy && !acc_clr_n) || row_valid);
         end
         if (row_valid) begin
            chk("rv_row", 32'(row_idx), rvs);
            if (rv_cyc == 0) rv_cyc = n;
            rvs++;
         end
         if (busy && !acc_clr_n) clrs++;
         if (err) errs++;
         if (done) begin
            done_cyc = n;
            fin = 1;
            mul_done = 1'b0;
         end
         if (!fin) tick();
      end
      chk("step_end", 32'(fin), 1);
   endtask

   initial begin
      int k;
      rst_async = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      mul_done = 1'b0;
      dim_m1 = 3'd0;
      tick();
      tick();
      chk("rst_flags", 32'({mul_start, row_valid, done, err, busy, acc_clr_n}), 0);
      chk("rst_idx", 32'({row_idx, col_idx}), 0);
      rst_async = 1'b0;
      tick();
      chk("idle_busy", 32'({busy, acc_clr_n}), 0);

      // D=1, multiplier answers in the first WAIT cycle
      run(0, 0, 0, 0, 0, 0);
      chk("d1_terms", terms, 1);
      chk("d1_clr", clrs, 1);
      chk("d1_ms_cyc", ms_cyc, 2);
      chk("d1_rv_cyc", rv_cyc, 4);
      chk("d1_done_cyc", done_cyc, 5);
      tick();
      chk("d1_idle", 32'({busy, done, row_valid}), 0);

      // D=3, zero-wait; indices held after the step
      run(2, 0, 0, 0, 0, 0);
      chk("d3_terms", terms, 9);
      chk("d3_rv", rvs, 3);
      chk("d3_clr", clrs, 3);
      chk("d3_done_cyc", done_cyc, 25);
      tick();
      chk("d3_busy", 32'(busy), 0);
      chk("d3_hold", 32'({row_idx, col_idx}), 32'(6'o22));

      // Largest system: D=8
      run(7, 0, 0, 0, 0, 0);
      chk("d8_terms", terms, 64);
      chk("d8_rv", rvs, 8);
      chk("d8_done_cyc", done_cyc, 145);
      tick();

      // Timeout on term (1,0)
      run(1, 0, 0, 1, 1, 0);
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (err) begin
            k = i;
            break;
         end
      end
      chk("to_cycles", k, 16);
      chk("to_flags", 32'({err, busy, acc_clr_n}), 32'(3'b100));
      mul_done = 1'b1;
      tick();
      chk("to_sticky", 32'(err), 1);
      mul_done = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("to_abort", 32'({err, busy, acc_clr_n}), 0);
      chk("to_abort_idx", 32'({row_idx, col_idx}), 0);

      // Extra start mid-step ignored; abort beats mul_done
      run(1, 0, 0, 1, 0, 1);
      dim_m1 = 3'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("st_ignored", 32'({busy, acc_clr_n, mul_start, col_idx}), 32'(6'b110001));
      mul_done = 1'b1;
      abort = 1'b1;
      tick();
      mul_done = 1'b0;
      abort = 1'b0;
      chk("ab_state", 32'({busy, row_valid, done, err}), 0);
      tick();
      chk("ab_quiet", 32'({busy, row_valid, done}), 0);

      // Reset in WAIT of term (2,1)
      run(2, 0, 0, 1, 2, 1);
      tick();
      tick();
      chk("mid_wait", 32'({busy, acc_clr_n, row_idx, col_idx}), 32'(8'b11_010001));
      rst_async = 1'b1;
      #1;
      chk("rst_async_flags", 32'({mul_start, row_valid, done, err, busy, acc_clr_n}), 0);
      chk("rst_async_idx", 32'({row_idx, col_idx}), 0);
      rst_async = 1'b0;
      tick();
      run(2, 0, 0, 0, 0, 0);
      chk("rerun_terms", terms, 9);
      chk("rerun_done_cyc", done_cyc, 25);
      tick();

      // Random multiplier latency plus spurious mul_done pulses
      run(3, 1, 1, 0, 0, 0);
      chk("rnd_terms", terms, 16);
      chk("rnd_rv", rvs, 4);
      chk("rnd_clr", clrs, 4);
      chk("rnd_err", errs, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/euler_acc_ctrl.md
Name: euler_acc_ctrl

Overview:
Sequencer for one Euler-step matrix-vector product, x_i(k+1) = x_i + h * sum_j A_ij x_j.
- For each row i it clears the accumulator buffer, then issues one multiply per column j.
- It waits for the done flag returned through the accumulator buffer after each multiply.
- It flags the row result to the write-back logic once the row is complete.
- It sits between the step controller (start/done) and the multiplier/accumulator datapath.
- It drives the buffer's active-low synchronous clear and consumes its done_mul_out.

Parameters:
- DIM_W, 3, width of the dimension and index fields; supported system size is 1..2^DIM_W.
- TO_CYC, 15, maximum number of WAIT cycles tolerated per multiply before an error is raised.
- TO_W, 4, width of the timeout counter; must satisfy 2^TO_W > TO_CYC.

Ports:
- clk, in, 1, system clock. Controller logic is posedge only.
- rst_async, in, 1, reset; asynchronous, active-high.
- start, in, 1, one-cycle request to run one step. Sampled only in IDLE.
- dim_m1, in, DIM_W, system dimension minus 1. Latched when start is accepted.
- abort, in, 1, synchronous abort, honoured in any state.
- mul_done, in, 1, multiply-accumulate complete. Driven by the accumulator buffer's done_mul_out.
- mul_start, out, 1, one-cycle multiply request.
- row_idx, out, DIM_W, current row i.
- col_idx, out, DIM_W, current column j.
- acc_clr_n, out, 1, accumulator clear, active-low. Drives the buffer's rst_sync.
- row_valid, out, 1, one-cycle strobe: the accumulator holds the complete sum for row_idx.
- busy, out, 1, a step is in progress.
- done, out, 1, one-cycle strobe: step complete.
- err, out, 1, multiply timeout. Sticky until abort or reset.

Behaviour:
General rules:
- States: IDLE, CLEAR, ISSUE, WAIT, ROWEND, FINISH, ERR.
- All outputs are decoded from registered state and counters. There is no combinational path from any input to any output.
- rst_async=1 takes effect immediately:
  - state=IDLE; row_idx=0, col_idx=0, latched dimension=0, timeout counter=0.
  - mul_start=0, row_valid=0, done=0, err=0, busy=0, acc_clr_n=0.
- acc_clr_n=0 in IDLE, CLEAR and ERR, and 1 in all other states. The buffer samples on negedge, so a one-cycle low clears it mid-cycle.
- busy=1 in every state except IDLE and ERR.

Transitions:
- IDLE:
  - start=1 → latch dim_m1; row=0, col=0; go to CLEAR.
  - start while busy is ignored, because start is not sampled outside IDLE.
- CLEAR: one cycle, then go to ISSUE.
- ISSUE:
  - mul_start=1 for exactly one cycle; timeout counter=0; go to WAIT.
  - mul_done in ISSUE is ignored.
- WAIT:
  - mul_done=1 and col==dim_m1 → go to ROWEND.
  - mul_done=1 and col!=dim_m1 → col+1, go to ISSUE.
  - Otherwise the timeout counter increments. When it reaches TO_CYC with mul_done=0, go to ERR.
  - If mul_done and the timeout occur in the same cycle, mul_done wins.
- ROWEND:
  - row_valid=1 for one cycle; the accumulator is not cleared in this cycle.
  - row==dim_m1 → go to FINISH.
  - Otherwise row+1, col=0, go to CLEAR.
- FINISH: done=1 for one cycle, then go to IDLE. row and col are held until the next start.
- ERR: err=1; the state holds until abort.

Abort and spurious inputs:
- abort=1 in any state → next state IDLE, err cleared, indices zeroed. No row_valid or done is emitted.
- abort takes priority over every other transition.
- mul_done in IDLE, CLEAR, ROWEND, FINISH or ERR is ignored and not counted.

Latency (multiplier returning mul_done in the first WAIT cycle):
- D = dim_m1+1. Each term takes 2 cycles; each row takes 2D+2 cycles.
- done is high in cycle D*(2D+2)+1 after the clock edge that samples start. Example: D=1 gives cycle 5.

Test Plan:
- Reset mid-WAIT (row 2, col 1) → all outputs return to their reset values immediately, state is IDLE, and a new start runs from row 0, col 0.
- dim_m1=0, start, mul_done one cycle after mul_start:
  - Sequence is CLEAR, ISSUE, WAIT, ROWEND, FINISH.
  - acc_clr_n low 1 cycle, mul_start at cycle 2, row_valid at cycle 4, done at cycle 5.
- dim_m1=2, zero-wait multiplier:
  - Exactly 9 mul_start pulses with (row,col) = (0,0)…(2,2) in row-major order.
  - 3 row_valid pulses and 3 acc_clr_n low pulses.
  - done at cycle 25.
- dim_m1=1, mul_done withheld on term (1,0):
  - err rises after 15 WAIT cycles; busy=0; acc_clr_n=0.
  - abort returns the block to IDLE with err=0.
- Random delay of 0..14 cycles on mul_done, plus spurious mul_done pulses in CLEAR and ROWEND → term count and row_valid count are unaffected, and err never asserts.
- start pulsed during a running step, and abort asserted in the same cycle as mul_done → the extra start is ignored, and abort wins: IDLE with no row_valid.
